// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, constants, state record and address helper for the fetch stage
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;

    localparam logic [PC_W-1:0]    PC_INC    = 32'd4;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    // pc: next address to issue; fpc: PC of the word on the memory data bus
    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] fpc;
        logic            fvalid;
    } fetch_state_t;

    // Byte PC to instruction-memory word index
    function automatic logic [PC_W-1:0] word_index(input logic [PC_W-1:0] byte_pc);
        return {2'b00, byte_pc[PC_W-1:2]};
    endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// fetch_next_pc: priority mux (redirect > stall > advance) for the issued address and next fetch state
// Optional build macro: FETCH_REDIRECT_BYPASS_EN (zero-bubble redirect)
module fetch_next_pc
    import fetch_pkg::*;
(
    input  logic               i_stall,
    input  logic               i_redirect_valid,
    input  logic [PC_W-1:0]    i_redirect_pc,
    input  fetch_state_t       i_cur,
    output logic [PC_W-1:0]    o_sel_pc,
    output fetch_state_t       o_next
);

    logic [PC_W-1:0] w_target;
    fetch_state_t    w_redir;
    fetch_state_t    w_adv;

    // Targets are word aligned; the two low bits of the request are dropped
    assign w_target = i_redirect_pc & ~32'd3;
    assign w_adv    = '{pc: i_cur.pc + PC_INC, fpc: i_cur.pc, fvalid: 1'b1};

`ifdef FETCH_REDIRECT_BYPASS_EN
    // Target goes straight to memory, so the word returned next edge is the target itself
    assign o_sel_pc = i_redirect_valid ? w_target : (i_stall ? i_cur.fpc : i_cur.pc);
    assign w_redir  = '{pc: w_target + PC_INC, fpc: w_target, fvalid: 1'b1};
`else
    // Data arriving next edge belongs to the stale pc, so it is marked invalid
    assign o_sel_pc = (i_stall && !i_redirect_valid) ? i_cur.fpc : i_cur.pc;
    assign w_redir  = '{pc: w_target, fpc: i_cur.fpc, fvalid: 1'b0};
`endif

    // Stalling re-reads the presented word so the memory output stays stable
    assign o_next = i_redirect_valid ? w_redir : (i_stall ? i_cur : w_adv);

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and instruction-fetch stage in front of a one-cycle synchronous instruction memory
// Optional build macro: FETCH_REDIRECT_BYPASS_EN (zero-bubble redirect)
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned     IMEM_DEPTH = 256
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_stall,
    input  logic               i_redirect_valid,
    input  logic [PC_W-1:0]    i_redirect_pc,
    output logic [PC_W-1:0]    o_imem_addr,
    input  logic [INSTR_W-1:0] i_imem_data,
    output logic               o_if_valid,
    output logic [PC_W-1:0]    o_if_pc,
    output logic [PC_W-1:0]    o_if_pc_plus4,
    output logic [INSTR_W-1:0] o_if_instr,
    output logic               o_if_fault
);

    fetch_state_t    r_state;
    fetch_state_t    w_next;
    logic [PC_W-1:0] w_sel_pc;

    fetch_next_pc u_next_pc (
        .i_stall          (i_stall),
        .i_redirect_valid (i_redirect_valid),
        .i_redirect_pc    (i_redirect_pc),
        .i_cur            (r_state),
        .o_sel_pc         (w_sel_pc),
        .o_next           (w_next)
    );

    // Fetch state; reset discards any in-flight word immediately
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_state <= '{pc: RESET_PC, fpc: '0, fvalid: 1'b0};
        else
            r_state <= w_next;
    end

    assign o_imem_addr   = word_index(w_sel_pc);
    assign o_if_valid    = r_state.fvalid;
    assign o_if_pc       = r_state.fpc;
    assign o_if_pc_plus4 = r_state.fpc + PC_INC;
    assign o_if_instr    = r_state.fvalid ? i_imem_data : NOP_INSTR;
    assign o_if_fault    = r_state.fvalid && (word_index(r_state.fpc) >= IMEM_DEPTH);

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven directed checks of fetch_unit plus reset and fault-boundary sequences
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall, redir;
    logic [31:0] rpc;
    logic [31:0] addr, data;
    logic        valid, fault;
    logic [31:0] pc, pc4, instr;

    logic [31:0] addr2, data2;
    logic        valid2, fault2;
    logic [31:0] pc2, pc42, instr2;

    logic [31:0] rom [4] = '{32'h00220020, 32'h00851824, 32'h00000000, 32'hAC000099};

    int n_tot  = 0;
    int n_pass = 0;

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
    } vec_t;

    vec_t v [22];

    fetch_unit dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_redirect_valid(redir),
        .i_redirect_pc(rpc), .o_imem_addr(addr), .i_imem_data(data),
        .o_if_valid(valid), .o_if_pc(pc), .o_if_pc_plus4(pc4),
        .o_if_instr(instr), .o_if_fault(fault)
    );

    fetch_unit #(.RESET_PC(32'h0000_03FC), .IMEM_DEPTH(256)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_stall(1'b0), .i_redirect_valid(1'b0),
        .i_redirect_pc(32'h0), .o_imem_addr(addr2), .i_imem_data(data2),
        .o_if_valid(valid2), .o_if_pc(pc2), .o_if_pc_plus4(pc42),
        .o_if_instr(instr2), .o_if_fault(fault2)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] w);
        if (w < 32'd4) return rom[w[1:0]];
        return {16'hC0DE, w[15:0]};
    endfunction

    always @(posedge clk) data  <= mem_word(addr);
    always @(posedge clk) data2 <= mem_word(addr2);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    endtask

    function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rp,
                                input logic [31:0] a, input logic vl, input logic [31:0] p);
        vec_t t;
        t.stall = s; t.redir = r; t.rpc = rp; t.addr = a; t.valid = vl; t.pc = p;
        return t;
    endfunction

    initial begin
        v[0]  = mk(0, 0, 32'h0, 32'h0, 1, 32'h0);
        v[1]  = mk(0, 0, 32'h0, 32'h1, 1, 32'h4);
        v[2]  = mk(1, 0, 32'h0, 32'h1, 1, 32'h4);
        v[3]  = mk(1, 0, 32'h0, 32'h1, 1, 32'h4);
        v[4]  = mk(1, 0, 32'h0, 32'h1, 1, 32'h4);
        v[5]  = mk(0, 0, 32'h0, 32'h2, 1, 32'h8);
        v[6]  = mk(0, 0, 32'h0, 32'h3, 1, 32'hC);
        v[7]  = mk(0, 0, 32'h0, 32'h4, 1, 32'h10);
`ifdef FETCH_REDIRECT_BYPASS_EN
        v[8]  = mk(0, 1, 32'hE, 32'h3, 1, 32'hC);
        v[9]  = mk(0, 0, 32'h0, 32'h4, 1, 32'h10);
        v[10] = mk(1, 1, 32'h0, 32'h0, 1, 32'h0);
        v[11] = mk(0, 0, 32'h0, 32'h1, 1, 32'h4);
        v[12] = mk(0, 0, 32'h0, 32'h2, 1, 32'h8);
        v[13] = mk(0, 1, 32'h8, 32'h2, 1, 32'h8);
        v[14] = mk(0, 1, 32'hC, 32'h3, 1, 32'hC);
        v[15] = mk(0, 0, 32'h0, 32'h4, 1, 32'h10);
        v[16] = mk(0, 1, 32'hFFFFFFFC, 32'h3FFFFFFF, 1, 32'hFFFFFFFC);
        v[17] = mk(0, 0, 32'h0, 32'h0, 1, 32'h0);
        v[18] = mk(0, 0, 32'h0, 32'h1, 1, 32'h4);
        v[19] = mk(0, 1, 32'h8, 32'h2, 1, 32'h8);
        v[20] = mk(1, 0, 32'h0, 32'h2, 1, 32'h8);
        v[21] = mk(0, 0, 32'h0, 32'h3, 1, 32'hC);
`else
        v[8]  = mk(0, 1, 32'hE, 32'h5, 0, 32'h0);
        v[9]  = mk(0, 0, 32'h0, 32'h3, 1, 32'hC);
        v[10] = mk(1, 1, 32'h0, 32'h4, 0, 32'h0);
        v[11] = mk(0, 0, 32'h0, 32'h0, 1, 32'h0);
        v[12] = mk(0, 0, 32'h0, 32'h1, 1, 32'h4);
        v[13] = mk(0, 1, 32'h8, 32'h2, 0, 32'h0);
        v[14] = mk(0, 1, 32'hC, 32'h2, 0, 32'h0);
        v[15] = mk(0, 0, 32'h0, 32'h3, 1, 32'hC);
        v[16] = mk(0, 1, 32'hFFFFFFFC, 32'h4, 0, 32'h0);
        v[17] = mk(0, 0, 32'h0, 32'h3FFFFFFF, 1, 32'hFFFFFFFC);
        v[18] = mk(0, 0, 32'h0, 32'h0, 1, 32'h0);
        v[19] = mk(0, 1, 32'h8, 32'h1, 0, 32'h0);
        v[20] = mk(1, 0, 32'h0, 32'h0, 0, 32'h0);
        v[21] = mk(0, 0, 32'h0, 32'h2, 1, 32'h8);
`endif

        rst_n = 1'b0; stall = 1'b0; redir = 1'b0; rpc = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset valid", {31'b0, valid}, 32'h0);
        chk("reset instr", instr, 32'h0);
        chk("reset pc", pc, 32'h0);
        chk("reset pc_plus4", pc4, 32'h4);
        chk("reset fault", {31'b0, fault}, 32'h0);
        chk("reset addr", addr, 32'h0);
        chk("reset addr dut2", addr2, 32'hFF);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 22; i++) begin
            stall = v[i].stall; redir = v[i].redir; rpc = v[i].rpc;
            #1;
            chk($sformatf("v%0d imem_addr", i), addr, v[i].addr);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d valid", i), {31'b0, valid}, {31'b0, v[i].valid});
            chk($sformatf("v%0d instr", i), instr, v[i].valid ? mem_word(v[i].pc >> 2) : 32'h0);
            if (v[i].valid) begin
                chk($sformatf("v%0d pc", i), pc, v[i].pc);
                chk($sformatf("v%0d pc_plus4", i), pc4, v[i].pc + 32'd4);
                chk($sformatf("v%0d fault", i), {31'b0, fault}, {31'b0, (v[i].pc >> 2) >= 32'd256});
            end
        end

        stall = 1'b0; redir = 1'b0; rpc = 32'h0;
        #2 rst_n = 1'b0;
        #1;
        chk("async reset valid", {31'b0, valid}, 32'h0);
        chk("async reset instr", instr, 32'h0);
        chk("async reset pc_plus4", pc4, 32'h4);
        chk("async reset addr", addr, 32'h0);
        chk("async reset valid dut2", {31'b0, valid2}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("restart valid", {31'b0, valid}, 32'h1);
        chk("restart pc", pc, 32'h0);
        chk("restart instr", instr, 32'h00220020);
        chk("dut2 first valid", {31'b0, valid2}, 32'h1);
        chk("dut2 first pc", pc2, 32'h3FC);
        chk("dut2 first instr", instr2, 32'hC0DE00FF);
        chk("dut2 first fault", {31'b0, fault2}, 32'h0);
        @(posedge clk);
        #1;
        chk("restart second pc", pc, 32'h4);
        chk("dut2 second pc", pc2, 32'h400);
        chk("dut2 second valid", {31'b0, valid2}, 32'h1);
        chk("dut2 second fault", {31'b0, fault2}, 32'h1);
        chk("dut2 second pc_plus4", pc42, 32'h404);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the instruction memory.
- Owns the program counter and drives the memory word address.
- Pairs each returned instruction with its PC and hands it downstream with a valid flag.
- Supports stall and branch/jump redirect; absorbs the memory's one-cycle synchronous read latency.

Parameters:
- RESET_PC, 32'h0000_0000, byte address fetched first after reset.
- IMEM_DEPTH, 256, number of 32-bit words in instruction memory; used for the fault check.

Ports:
- clk  in  1  rising-edge clock, shared with instruction memory.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  downstream cannot accept; hold the current instruction.
- redirect_valid  in  1  taken branch/jump this cycle.
- redirect_pc  in  32  byte target address; bits [1:0] are ignored.
- imem_addr  out  32  word index to memory, {2'b00, sel_pc[31:2]}.
- imem_data  in  32  memory read data, valid one edge after the address.
- if_valid  out  1  if_instr/if_pc are a real instruction.
- if_pc  out  32  byte PC of if_instr.
- if_pc_plus4  out  32  if_pc + 4, modulo 2^32.
- if_instr  out  32  instruction; 32'h0 when if_valid=0.
- if_fault  out  1  if_valid && (if_pc[31:2] >= IMEM_DEPTH).

Behaviour:
- State registers:
  - pc_q: next address to issue.
  - fpc_q: PC of the word currently on imem_data.
  - fvalid_q.
- Reset (async, rst_n=0): pc_q=RESET_PC, fpc_q=0, fvalid_q=0. Outputs: if_valid=0, if_instr=0, if_pc=0, if_pc_plus4=4, if_fault=0.
- Address select (combinational), in priority order:
  - stall && !redirect_valid: sel_pc=fpc_q. The memory re-reads the presented word, so the output stays stable.
  - otherwise: sel_pc=pc_q.
- Register update each edge, priority redirect > stall > advance:
  - redirect_valid: pc_q={redirect_pc[31:2],2'b00}; fvalid_q=0. This gives a one-cycle bubble, because the data arriving next belongs to the stale pc_q.
  - stall: all registers hold.
  - else: fpc_q=pc_q; fvalid_q=1; pc_q=pc_q+4 (wraps 0xFFFFFFFC -> 0).
- Latency:
  - First valid instruction appears after the first edge with rst_n=1, at if_pc=RESET_PC.
  - Sustained throughput is 1 instr/cycle.
- Outputs: if_valid=fvalid_q; if_pc=fpc_q; if_instr=fvalid_q ? imem_data : 0.
- Stall while if_valid=0: hold; no instruction is lost.
- Redirect while stalled: redirect wins; the held instruction is dropped.
- Redirect on consecutive cycles: the last target wins; if_valid stays 0 until one cycle after redirect deasserts.
- Reset mid-stream: immediate return to reset values; in-flight data is discarded.
- No internal state machine beyond valid/pc registers. Stall/redirect timing is the sole handshake: the consumer samples if_* on edges where if_valid=1 && stall=0.

Optional Feature:
- Macro: FETCH_REDIRECT_BYPASS_EN.
- Defined:
  - On redirect_valid, sel_pc=redirect_pc (combinational into imem_addr).
  - Registers: fpc_q={redirect_pc[31:2],2'b00}, fvalid_q=1, pc_q=target+4.
  - Zero-bubble redirect; if_valid stays high across the redirect.
- Undefined: one-bubble behaviour as above.
- Stall handling is identical in both builds.

Decomposition:
- Package fetch_pkg:
  - INSTR_W=32, PC_W=32, PC_INC=32'd4.
  - NOP_INSTR=32'h0000_0000.
  - Word-index helper function (byte PC -> imem_addr).
- One natural sub-module, fetch_next_pc: the combinational priority mux producing sel_pc and next pc_q from stall/redirect/pc_q/fpc_q. The top keeps the registers.

Test Plan:
- Bench memory loaded with mem[0]=32'h00220020, mem[1]=32'h00851824, mem[2]=32'h00000000, mem[3]=32'hAC000099.
- Reset then run: if_valid rises after the first edge; sequence (pc,instr) = (0,00220020), (4,00851824), (8,0), (C,AC000099); imem_addr = 0,1,2,3.
- Stall 3 cycles while if_pc=4: if_instr holds 00851824, imem_addr=1 during stall; resumes with pc=8 the cycle after release.
- Redirect to 32'h0000000E at if_pc=4: next cycle if_valid=0; then (pc=C, instr=AC000099); low bits ignored. With FETCH_REDIRECT_BYPASS_EN: no bubble.
- Redirect and stall asserted together: redirect wins; the stalled instruction is never re-presented.
- RESET_PC=32'h3FC, IMEM_DEPTH=256: pc 0x3FC valid with if_fault=0, next pc 0x400 gives if_fault=1. Separately, redirect to 0xFFFFFFFC: next if_pc wraps to 0.
- Assert rst_n=0 mid-stream between edges: if_valid drops to 0 immediately; after release, the fetch restarts at RESET_PC.
